// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator for a 640x480 @ 60 Hz raster (25 MHz pixel clock).
// Two 10-bit counters walk the full line/frame including blanking. Every output is a
// registered decode of the counter values from before the increment, so outputs trail
// the counters by exactly one pix_en step. Holding pix_en low freezes the counters and
// the level outputs; the line_start/frame_start pulses are cleared on such edges.
// Optional feature: define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter
// output (frame_cnt) that steps on every edge that raises frame_start.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       CLOCK_25,
    input  logic       RESET_N,
    input  logic       pix_en,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       DISP_EN,
    output logic       VGA_BLANK_N,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX  = 10'(H_TOT - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic [9:0] px_q, px_d;
    logic [9:0] py_q, py_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;
`endif

    // Next-state: advance counters and load the decode of the current position on pix_en.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        px_d    = px_q;
        py_d    = py_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
`ifdef VGA_FRAME_CNT_EN
        fc_d    = fc_q;
`endif
        if (pix_en) begin
            hs_d = !((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE));
            vs_d = !((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE));
            de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            px_d = h_cnt_q;
            py_d = v_cnt_q;
            ls_d = (h_cnt_q == 10'd0);
            fs_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
`ifdef VGA_FRAME_CNT_EN
            if ((h_cnt_q == 10'd0) && (v_cnt_q == 10'd0)) begin
                fc_d = fc_q + 8'd1;
            end
`endif
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // State and output registers; reset parks the raster at the origin with syncs idle.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            px_q    <= 10'd0;
            py_q    <= 10'd0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            fc_q    <= 8'd0;
`endif
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            px_q    <= px_d;
            py_q    <= py_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
`ifdef VGA_FRAME_CNT_EN
            fc_q    <= fc_d;
`endif
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign DISP_EN     = de_q;
    assign VGA_BLANK_N = de_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt   = fc_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen.
// dut_a uses the 640x480 default timing for reset and first-line edge checks.
// dut_b uses a tiny raster (H: 8/2/3/2 = 15, V: 4/1/2/1 = 8, frame = 120 clocks) so
// whole-frame periods and the pix_en stretching can be observed in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, pen_a, rst_b, pen_b;

    logic       hs_a, vs_a, de_a, bn_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, de_b, bn_b, ls_b, fs_b;
    logic [9:0] px_b, py_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut_a (
        .CLOCK_25(clk), .RESET_N(rst_a), .pix_en(pen_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .DISP_EN(de_a), .VGA_BLANK_N(bn_a),
        .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .CLOCK_25(clk), .RESET_N(rst_b), .pix_en(pen_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .DISP_EN(de_b), .VGA_BLANK_N(bn_b),
        .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    // {HS, VS, DISP_EN, BLANK_N, pixel_x, pixel_y, line_start, frame_start}
    localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    wire [27:0] vec_a = {hs_a, vs_a, de_a, bn_a, px_a, py_a, ls_a, fs_a};
    wire [27:0] vec_b = {hs_b, vs_b, de_b, bn_b, px_b, py_b, ls_b, fs_b};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; pen_a = 1'b1; pen_b = 1'b1;
        repeat (4) tick();
        checks++;
        if (vec_a !== RST_VEC) begin
            errors++; $display("FAIL reset_hold_a: got %h want %h", vec_a, RST_VEC);
        end
        checks++;
        if (vec_b !== RST_VEC) begin
            errors++; $display("FAIL reset_hold_b: got %h want %h", vec_b, RST_VEC);
        end
        // run off the origin, then assert reset between edges
        rst_a = 1'b1;
        repeat (5) tick();
        checks++;
        if (px_a !== 10'd4 || de_a !== 1'b1) begin
            errors++; $display("FAIL pre_async: got px=%0d de=%b want px=4 de=1", px_a, de_a);
        end
        #3;
        rst_a = 1'b0;
        #1;
        checks++;
        if (vec_a !== RST_VEC) begin
            errors++; $display("FAIL reset_async: got %h want %h", vec_a, RST_VEC);
        end
    endtask

    task automatic test_first_line();
        int ls_count;
        ls_count = 0;
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        pen_a = 1'b1;
        for (int e = 1; e <= 801; e++) begin
            tick();
            if (ls_a === 1'b1) ls_count++;
            if (e == 1) begin
                checks++;
                if ({fs_a, ls_a, de_a, bn_a, px_a, py_a} !== {4'b1111, 10'd0, 10'd0}) begin
                    errors++;
                    $display("FAIL edge1: got fs=%b ls=%b de=%b bn=%b px=%0d py=%0d want 1 1 1 1 0 0",
                             fs_a, ls_a, de_a, bn_a, px_a, py_a);
                end
            end
            if (e == 2) begin
                checks++;
                if ({fs_a, ls_a} !== 2'b00 || px_a !== 10'd1) begin
                    errors++; $display("FAIL edge2: got fs=%b ls=%b px=%0d want 0 0 1", fs_a, ls_a, px_a);
                end
            end
            if (e == 640 || e == 641) begin
                checks++;
                if (de_a !== (e == 640) || bn_a !== de_a) begin
                    errors++; $display("FAIL de_edge%0d: got de=%b bn=%b want %b", e, de_a, bn_a, e == 640);
                end
            end
            if (e == 656 || e == 657 || e == 752 || e == 753) begin
                checks++;
                if (hs_a !== (e == 656 || e == 753)) begin
                    errors++; $display("FAIL hs_edge%0d: got %b want %b", e, hs_a, (e == 656 || e == 753));
                end
            end
            if (e == 801) begin
                checks++;
                if ({ls_a, fs_a, px_a, py_a, vs_a} !== {1'b1, 1'b0, 10'd0, 10'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL edge801: got ls=%b fs=%b px=%0d py=%0d vs=%b want 1 0 0 1 1",
                             ls_a, fs_a, px_a, py_a, vs_a);
                end
            end
        end
        checks++;
        if (ls_count != 2) begin
            errors++; $display("FAIL line_start_count: got %0d want 2", ls_count);
        end
    endtask

    task automatic test_reset_midframe();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (px_a == 10'd300 && py_a == 10'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midframe_reach: got px=%0d py=%0d want 300 2", px_a, py_a);
        end
        #3;
        rst_a = 1'b0;
        #1;
        checks++;
        if (vec_a !== RST_VEC) begin
            errors++; $display("FAIL midframe_reset: got %h want %h", vec_a, RST_VEC);
        end
        repeat (3) tick();
        rst_a = 1'b1;
        tick();
        checks++;
        if ({fs_a, ls_a, px_a, py_a} !== {2'b11, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL midframe_restart: got fs=%b ls=%b px=%0d py=%0d want 1 1 0 0", fs_a, ls_a, px_a, py_a);
        end
        tick();
        checks++;
        if (fs_a !== 1'b0 || px_a !== 10'd1) begin
            errors++; $display("FAIL midframe_next: got fs=%b px=%0d want 0 1", fs_a, px_a);
        end
    endtask

    task automatic test_frame_periods();
        logic [31:0] exp_q[$];
        logic [31:0] fs_edges[$];
        int vs_low, vs_first, de_high, ls_cnt, hs_low, hs_first;
        vs_low = 0; vs_first = 0; de_high = 0; ls_cnt = 0; hs_low = 0; hs_first = 0;
        exp_q = '{32'd1, 32'd121, 32'd241, 32'd361};
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        pen_b = 1'b1;
        for (int e = 1; e <= 361; e++) begin
            tick();
            if (fs_b === 1'b1) fs_edges.push_back(32'(e));
            if (e <= 120) begin
                if (vs_b === 1'b0) begin
                    vs_low++;
                    if (vs_first == 0) vs_first = e;
                end
                if (de_b === 1'b1) de_high++;
                if (ls_b === 1'b1) ls_cnt++;
            end
            if (e <= 15 && hs_b === 1'b0) begin
                hs_low++;
                if (hs_first == 0) hs_first = e;
            end
        end
        checks++;
        if (fs_edges.size() != exp_q.size()) begin
            errors++; $display("FAIL fs_count: got %0d want %0d", fs_edges.size(), exp_q.size());
        end
        while (fs_edges.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] got, want;
            got = fs_edges.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL fs_edge: got %0d want %0d", got, want);
            end
        end
        checks++;
        if (vs_low != 30 || vs_first != 76) begin
            errors++; $display("FAIL vs_window: got len=%0d start=%0d want 30 76", vs_low, vs_first);
        end
        checks++;
        if (de_high != 32 || ls_cnt != 8) begin
            errors++; $display("FAIL frame_counts: got de=%0d ls=%0d want 32 8", de_high, ls_cnt);
        end
        checks++;
        if (hs_low != 3 || hs_first != 11) begin
            errors++; $display("FAIL hs_window: got len=%0d start=%0d want 3 11", hs_low, hs_first);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (fc_b !== 8'd4) begin
            errors++; $display("FAIL frame_cnt: got %0d want 4", fc_b);
        end
`endif
    endtask

    task automatic test_pix_en_alternate();
        int ls_edges[$];
        int fs_cnt, de_high, hold_bad, back_to_back;
        logic [9:0] prev_px;
        logic prev_ls;
        fs_cnt = 0; de_high = 0; hold_bad = 0; back_to_back = 0; prev_ls = 1'b0;
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        for (int e = 1; e <= 241; e++) begin
            pen_b = (e % 2 == 1);
            prev_px = px_b;
            tick();
            if (!pen_b && px_b !== prev_px) hold_bad++;
            if (ls_b === 1'b1) begin
                if (e <= 240) ls_edges.push_back(e);
                if (prev_ls) back_to_back++;
            end
            prev_ls = ls_b;
            if (fs_b === 1'b1 && e <= 240) fs_cnt++;
            if (e <= 240 && de_b === 1'b1) de_high++;
        end
        pen_b = 1'b1;
        checks++;
        if (hold_bad != 0) begin
            errors++; $display("FAIL hold_px: got %0d changes want 0", hold_bad);
        end
        checks++;
        if (ls_edges.size() != 8 || back_to_back != 0) begin
            errors++;
            $display("FAIL alt_ls: got count=%0d b2b=%0d want 8 0", ls_edges.size(), back_to_back);
        end
        checks++;
        if (ls_edges.size() < 2 || ls_edges[0] != 1 || ls_edges[1] != 31) begin
            errors++; $display("FAIL alt_ls_period: got first two line_start edges wrong, want 1 31");
        end
        checks++;
        if (fs_cnt != 1 || fs_b !== 1'b1) begin
            errors++; $display("FAIL alt_fs: got count=%0d fs@241=%b want 1 1", fs_cnt, fs_b);
        end
        checks++;
        if (de_high != 64) begin
            errors++; $display("FAIL alt_de: got %0d want 64", de_high);
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; pen_a = 1'b0; pen_b = 1'b0;
        #2;
        test_reset();
        test_first_line();
        test_reset_midframe();
        test_frame_periods();
        test_pix_en_alternate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
